// File: rtl/mpy_seq_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mpy_seq_pkg
// Purpose  : Shared definitions for the sequential multiplier: operation
//            encodings, flag bit positions and FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mpy_seq_pkg;

  // i_op encodings: bit1 selects the high word, bit0 selects signed operands
  localparam logic [1:0] MPY_LO  = 2'b00;
  localparam logic [1:0] MPY_SLO = 2'b01;
  localparam logic [1:0] MPY_UHI = 2'b10;
  localparam logic [1:0] MPY_SHI = 2'b11;

  // Bit positions inside o_flags = {V, N, C, Z}
  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SIGN = 2'd1,
    ST_RUN  = 2'd2,
    ST_NEG  = 2'd3
  } mpy_state_e;

endpackage
`default_nettype wire

// File: rtl/mpy_seq_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mpy_seq_if
// Purpose  : Start/busy/valid handshake bundle between the execute-stage
//            controller (master) and the sequential multiplier (slave).
// Signals  : i_wr     start strobe, operands sampled in the same cycle
//            i_op     {high word, signed}
//            i_a/i_b  multiplicand / multiplier
//            o_busy   operation in progress
//            o_valid  single-cycle result strobe
//            o_result selected product word
//            o_flags  {V, N, C, Z}
// Revision : 1.0 - initial release
// ============================================================================
interface mpy_seq_if #(
  parameter int BW = 32
);
  logic          i_wr;
  logic [1:0]    i_op;
  logic [BW-1:0] i_a;
  logic [BW-1:0] i_b;
  logic          o_busy;
  logic          o_valid;
  logic [BW-1:0] o_result;
  logic [3:0]    o_flags;

  modport master (
    output i_wr, i_op, i_a, i_b,
    input  o_busy, o_valid, o_result, o_flags
  );

  modport slave (
    input  i_wr, i_op, i_a, i_b,
    output o_busy, o_valid, o_result, o_flags
  );
endinterface
`default_nettype wire

// File: rtl/mpy_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mpy_seq
// Purpose  : Iterative shift-and-add BW x BW multiplier returning either word
//            of the 2*BW-bit product (signed or unsigned) with ALU flags.
//            Latency: o_valid appears BW+3 cycles after the i_wr cycle.
// Ports    : i_clk  clock
//            i_rst  synchronous active-high reset
//            bus    mpy_seq_if.slave handshake (i_wr/i_op/i_a/i_b in,
//                   o_busy/o_valid/o_result/o_flags out)
// Revision : 1.0 - initial release
// ============================================================================
module mpy_seq
  import mpy_seq_pkg::*;
#(
  parameter int BW   = 32,
  parameter int LGBW = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  mpy_seq_if.slave    bus
);

  mpy_state_e        state_q, state_d;
  logic [2*BW-1:0]   mcand_q, mcand_d;   // multiplicand, shifted left each RUN cycle
  logic [2*BW-1:0]   acc_q,   acc_d;
  logic [BW-1:0]     mplier_q, mplier_d; // multiplier, shifted right each RUN cycle
  logic [LGBW-1:0]   cnt_q,   cnt_d;
  logic [1:0]        op_q,    op_d;
  logic              sign_q,  sign_d;
  logic              valid_q, valid_d;
  logic [BW-1:0]     result_q, result_d;
  logic [3:0]        flags_q, flags_d;

  logic [BW-1:0]     w_mcand_mag;
  logic [BW-1:0]     w_mplier_mag;
  logic [2*BW-1:0]   w_prod;
  logic [BW-1:0]     w_word;
  logic [BW-1:0]     w_other;

  // Two's-complement magnitude; the most negative value maps onto itself,
  // which is the correct unsigned magnitude.
  assign w_mcand_mag  = mcand_q[BW-1] ? (~mcand_q[BW-1:0] + BW'(1)) : mcand_q[BW-1:0];
  assign w_mplier_mag = mplier_q[BW-1] ? (~mplier_q + BW'(1)) : mplier_q;

  // Final product with the recorded sign re-applied across the full width,
  // so the carry flag sees the true signed 2*BW result.
  assign w_prod  = sign_q ? (~acc_q + (2*BW)'(1)) : acc_q;
  assign w_word  = op_q[1] ? w_prod[2*BW-1:BW] : w_prod[BW-1:0];
  assign w_other = op_q[1] ? w_prod[BW-1:0]    : w_prod[2*BW-1:BW];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_d   = sign_q;
    valid_d  = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;

    // A start strobe restarts from any state; an in-flight operation is
    // dropped without ever raising o_valid.
    if (bus.i_wr) begin
      op_d     = bus.i_op;
      mcand_d  = {{BW{1'b0}}, bus.i_a};
      mplier_d = bus.i_b;
      acc_d    = '0;
      cnt_d    = LGBW'(BW - 1);
      sign_d   = 1'b0;
      state_d  = ST_SIGN;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end

        ST_SIGN: begin
          if (op_q[0]) begin
            mcand_d  = {{BW{1'b0}}, w_mcand_mag};
            mplier_d = w_mplier_mag;
            sign_d   = mcand_q[BW-1] ^ mplier_q[BW-1];
          end else begin
            sign_d   = 1'b0;
          end
          state_d = ST_RUN;
        end

        ST_RUN: begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - LGBW'(1);
          if (cnt_q == '0) begin
            state_d = ST_NEG;
          end
        end

        ST_NEG: begin
          result_d         = w_word;
          flags_d[FLAG_V]  = 1'b0;
          flags_d[FLAG_N]  = w_word[BW-1];
          flags_d[FLAG_C]  = |w_other;
          flags_d[FLAG_Z]  = (w_word == '0);
          valid_d          = 1'b1;
          state_d          = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy   = (state_q != ST_IDLE);
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign bus.o_flags  = flags_q;

endmodule
`default_nettype wire
